// File: rtl/shift_issue_pkg.sv
// Shared constants for the shift issue stage: funct3 codes, FSM states, width defaults.
// Forwarding is enabled by defining SHIFT_ISSUE_FWD_EN.
package shift_issue_pkg;
    localparam int XLEN_DEF    = 32;
    localparam int SHAMT_W_DEF = 5;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;
endpackage

// File: rtl/shift_issue_decode.sv
// Combinational decode of funct3/funct7b5 into shifter mode, direction and illegal flag.
module shift_decode
    import shift_issue_pkg::*;
(
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output logic       o_mode,
    output logic       o_direction,
    output logic       o_illegal
);

    // Legal encodings select mode/direction; everything else is illegal with zeroed controls.
    always_comb begin
        o_mode      = 1'b0;
        o_direction = 1'b0;
        o_illegal   = 1'b0;
        case ({i_funct7b5, i_funct3})
            {1'b0, F3_SLL}: begin
                o_mode      = 1'b0;
                o_direction = 1'b0;
            end
            {1'b0, F3_SR}: begin
                o_mode      = 1'b0;
                o_direction = 1'b1;
            end
            {1'b1, F3_SR}: begin
                o_mode      = 1'b1;
                o_direction = 1'b1;
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/shift_issue.sv
// Shift-instruction issue stage: decode, operand forming and a two-entry skid buffer.
// Define SHIFT_ISSUE_FWD_EN to enable writeback forwarding (adds rs index inputs).
module shift_issue
    import shift_issue_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int SHAMT_W = SHAMT_W_DEF
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [2:0]         i_funct3,
    input  logic               i_funct7b5,
    input  logic               i_is_imm,
    input  logic [XLEN-1:0]    i_rs1_data,
    input  logic [XLEN-1:0]    i_rs2_data,
    input  logic [SHAMT_W-1:0] i_shamt,
    input  logic [4:0]         i_rd,
`ifdef SHIFT_ISSUE_FWD_EN
    input  logic [4:0]         i_rs1_idx,
    input  logic [4:0]         i_rs2_idx,
`endif
    input  logic               i_wb_valid,
    input  logic [4:0]         i_wb_rd,
    input  logic [XLEN-1:0]    i_wb_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic               o_mode,
    output logic               o_direction,
    output logic [XLEN-1:0]    o_a,
    output logic [XLEN-1:0]    o_b,
    output logic [4:0]         o_rd,
    output logic               o_illegal
);

    typedef struct packed {
        logic            mode;
        logic            direction;
        logic            illegal;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
    } entry_t;

    state_e          r_state;
    logic            r_valid;
    logic            r_ready;
    entry_t          r_out;
    entry_t          r_skid;

    logic            w_mode;
    logic            w_direction;
    logic            w_illegal;
    logic [XLEN-1:0] w_rs1;
    logic [XLEN-1:0] w_rs2;
    entry_t          w_new;
    logic            w_push;
    logic            w_pop;
    logic            w_unused;

    shift_decode u_decode (
        .i_funct3    (i_funct3),
        .i_funct7b5  (i_funct7b5),
        .o_mode      (w_mode),
        .o_direction (w_direction),
        .o_illegal   (w_illegal)
    );

`ifdef SHIFT_ISSUE_FWD_EN
    assign w_rs1 = (i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs1_idx)) ? i_wb_data : i_rs1_data;
    assign w_rs2 = (i_wb_valid && (i_wb_rd != 5'd0) && (i_wb_rd == i_rs2_idx)) ? i_wb_data : i_rs2_data;
    assign w_unused = ^w_rs2[XLEN-1:SHAMT_W];
`else
    assign w_rs1 = i_rs1_data;
    assign w_rs2 = i_rs2_data;
    assign w_unused = ^{i_wb_valid, i_wb_rd, i_wb_data, w_rs2[XLEN-1:SHAMT_W]};
`endif

    assign w_new.mode      = w_mode;
    assign w_new.direction = w_direction;
    assign w_new.illegal   = w_illegal;
    assign w_new.a         = w_rs1;
    assign w_new.b         = i_is_imm ? {{(XLEN-SHAMT_W){1'b0}}, i_shamt}
                                      : {{(XLEN-SHAMT_W){1'b0}}, w_rs2[SHAMT_W-1:0]};
    assign w_new.rd        = i_rd;

    assign w_push = i_valid && r_ready;
    assign w_pop  = r_valid && i_ready;

    // Skid-buffer FSM; ready/valid are registered alongside the state so they track it exactly.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
            r_ready <= 1'b0;
            r_out   <= '0;
            r_skid  <= '0;
        end else begin
            case (r_state)
                EMPTY: begin
                    r_ready <= 1'b1;
                    if (w_push) begin
                        r_out   <= w_new;
                        r_valid <= 1'b1;
                        r_state <= ONE;
                    end
                end
                ONE: begin
                    if (w_push && !w_pop) begin
                        r_skid  <= w_new;
                        r_ready <= 1'b0;
                        r_state <= FULL;
                    end else if (w_push && w_pop) begin
                        r_out   <= w_new;
                    end else if (w_pop) begin
                        r_valid <= 1'b0;
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_out   <= r_skid;
                        r_ready <= 1'b1;
                        r_state <= ONE;
                    end
                end
                default: begin
                    r_state <= EMPTY;
                    r_valid <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_valid     = r_valid;
    assign o_ready     = r_ready;
    assign o_mode      = r_out.mode;
    assign o_direction = r_out.direction;
    assign o_illegal   = r_out.illegal;
    assign o_a         = r_out.a;
    assign o_b         = r_out.b;
    assign o_rd        = r_out.rd;

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue: directed scenarios plus random traffic against a FIFO model.
module tb_shift_issue;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [2:0]  i_funct3;
    logic        i_funct7b5;
    logic        i_is_imm;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic [4:0]  i_shamt;
    logic [4:0]  i_rd;
    logic [4:0]  i_rs1_idx;
    logic [4:0]  i_rs2_idx;
    logic        i_wb_valid;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_valid;
    logic        i_ready;
    logic        o_mode;
    logic        o_direction;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [4:0]  o_rd;
    logic        o_illegal;

    typedef struct packed {
        logic        mode;
        logic        dir;
        logic        ill;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
    } exp_t;

    exp_t q[$];
    bit   rdy_en;
    int   errors;
    int   checks;

    shift_issue dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_funct3    (i_funct3),
        .i_funct7b5  (i_funct7b5),
        .i_is_imm    (i_is_imm),
        .i_rs1_data  (i_rs1_data),
        .i_rs2_data  (i_rs2_data),
        .i_shamt     (i_shamt),
        .i_rd        (i_rd),
`ifdef SHIFT_ISSUE_FWD_EN
        .i_rs1_idx   (i_rs1_idx),
        .i_rs2_idx   (i_rs2_idx),
`endif
        .i_wb_valid  (i_wb_valid),
        .i_wb_rd     (i_wb_rd),
        .i_wb_data   (i_wb_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_mode      (o_mode),
        .o_direction (o_direction),
        .o_a         (o_a),
        .o_b         (o_b),
        .o_rd        (o_rd),
        .o_illegal   (o_illegal)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected result of the instruction currently on the inputs, from the ISA rules.
    function automatic exp_t model_entry();
        exp_t        e;
        logic [31:0] op1;
        logic [31:0] op2;
        op1 = i_rs1_data;
        op2 = i_rs2_data;
`ifdef SHIFT_ISSUE_FWD_EN
        if (i_wb_valid && i_wb_rd != 5'd0 && i_wb_rd == i_rs1_idx) op1 = i_wb_data;
        if (i_wb_valid && i_wb_rd != 5'd0 && i_wb_rd == i_rs2_idx) op2 = i_wb_data;
`endif
        e.a  = op1;
        e.b  = i_is_imm ? {27'd0, i_shamt} : (op2 % 32'd32);
        e.rd = i_rd;
        e.mode = 1'b0; e.dir = 1'b0; e.ill = 1'b0;
        if (i_funct3 == 3'd1 && !i_funct7b5)      begin e.dir = 1'b0; end
        else if (i_funct3 == 3'd5 && !i_funct7b5) begin e.dir = 1'b1; end
        else if (i_funct3 == 3'd5 && i_funct7b5)  begin e.mode = 1'b1; e.dir = 1'b1; end
        else                                      begin e.ill = 1'b1; end
        return e;
    endfunction

    task automatic check_outputs();
        chk("o_valid", o_valid, q.size() > 0);
        chk("o_ready", o_ready, rdy_en && q.size() < 2);
        if (q.size() > 0) begin
            chk("o_mode", o_mode, q[0].mode);
            chk("o_dir", o_direction, q[0].dir);
            chk("o_illegal", o_illegal, q[0].ill);
            chk("o_a", o_a, q[0].a);
            chk("o_b", o_b, q[0].b);
            chk("o_rd", o_rd, q[0].rd);
        end
    endtask

    // One clock: predict transfers from the model's own occupancy, advance, then check at negedge.
    task automatic step();
        bit   push;
        bit   pop;
        exp_t e;
        push = i_valid && rdy_en && q.size() < 2;
        pop  = i_ready && q.size() > 0;
        e    = model_entry();
        @(posedge i_clk);
        if (pop)  void'(q.pop_front());
        if (push) q.push_back(e);
        rdy_en = 1'b1;
        @(negedge i_clk);
        check_outputs();
    endtask

    task automatic drive(input logic v, input logic [2:0] f3, input logic f7, input logic imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] sh,
                         input logic [4:0] rd, input logic rdy);
        i_valid = v; i_funct3 = f3; i_funct7b5 = f7; i_is_imm = imm;
        i_rs1_data = rs1; i_rs2_data = rs2; i_shamt = sh; i_rd = rd; i_ready = rdy;
    endtask

    initial begin
        errors = 0; checks = 0; rdy_en = 1'b0;
        i_rst_n = 1'b0;
        i_rs1_idx = 5'd0; i_rs2_idx = 5'd0;
        i_wb_valid = 1'b0; i_wb_rd = 5'd0; i_wb_data = 32'd0;
        drive(1'b0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0, 1'b0);
        #12;
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_ready", o_ready, 1'b0);
        chk("rst_fields", {o_mode, o_direction, o_illegal, o_a, o_b, o_rd}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        #1 chk("ready_before_edge", o_ready, 1'b0);
        step();
        chk("ready_after_release", o_ready, 1'b1);

        // SRAI 0x8000_0000 by 4
        drive(1'b1, 3'd5, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 5'd4, 5'd7, 1'b1);
        step();
        chk("srai_valid", o_valid, 1'b1);
        chk("srai_mode_dir", {o_mode, o_direction}, 2'b11);
        chk("srai_a", o_a, 32'h8000_0000);
        chk("srai_b", o_b, 32'd4);

        // SLL register form: only rs2[4:0] survives
        drive(1'b1, 3'd1, 1'b0, 1'b0, 32'h0000_00FF, 32'hFFFF_FF23, 5'd31, 5'd8, 1'b1);
        step();
        chk("sll_b", o_b, 32'h0000_0003);
        chk("sll_mode_dir", {o_mode, o_direction}, 2'b00);

        // Illegal encoding still flows
        drive(1'b1, 3'd1, 1'b1, 1'b0, 32'h1, 32'h2, 5'd0, 5'd9, 1'b1);
        step();
        chk("ill_flag", o_illegal, 1'b1);
        chk("ill_mode_dir", {o_mode, o_direction}, 2'b00);
        i_valid = 1'b0;
        step();
        chk("ill_drained", o_valid, 1'b0);

        // Three back-to-back pushes against a stalled sink
        drive(1'b1, 3'd5, 1'b0, 1'b1, 32'hA, 32'd0, 5'd1, 5'd11, 1'b0);
        step();
        drive(1'b1, 3'd5, 1'b0, 1'b1, 32'hB, 32'd0, 5'd2, 5'd12, 1'b0);
        step();
        chk("bp_ready_low", o_ready, 1'b0);
        drive(1'b1, 3'd5, 1'b0, 1'b1, 32'hC, 32'd0, 5'd3, 5'd13, 1'b0);
        step();
        chk("bp_hold_rd", o_rd, 5'd11);
        i_ready = 1'b1;
        step();
        chk("bp_second_rd", o_rd, 5'd12);
        step();
        chk("bp_third_rd", o_rd, 5'd13);
        i_valid = 1'b0;
        step();
        chk("bp_empty", o_valid, 1'b0);

        // Reset while FULL
        drive(1'b1, 3'd1, 1'b0, 1'b1, 32'h55, 32'd0, 5'd5, 5'd20, 1'b0);
        step();
        i_rd = 5'd21;
        step();
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1 chk("midrst_valid", o_valid, 1'b0);
        chk("midrst_ready", o_ready, 1'b0);
        q.delete();
        rdy_en = 1'b0;
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_ready = 1'b1;
        step();
        chk("postrst_no_stale", o_valid, 1'b0);

        // Writeback forwarding source
        i_rs1_idx = 5'd5; i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'h0000_1234;
        drive(1'b1, 3'd5, 1'b0, 1'b1, 32'hDEAD_BEEF, 32'd0, 5'd1, 5'd3, 1'b1);
        step();
`ifdef SHIFT_ISSUE_FWD_EN
        chk("fwd_a", o_a, 32'h0000_1234);
`else
        chk("nofwd_a", o_a, 32'hDEAD_BEEF);
`endif
        i_rs1_idx = 5'd0; i_wb_rd = 5'd0;
        step();
        chk("fwd_x0_a", o_a, 32'hDEAD_BEEF);
        i_valid = 1'b0; i_wb_valid = 1'b0;
        step();

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            i_valid    = 1'($urandom_range(0, 3) != 0);
            i_funct3   = ($urandom_range(0, 3) == 0) ? 3'($urandom) : (($urandom_range(0, 1) != 0) ? 3'd1 : 3'd5);
            i_funct7b5 = 1'($urandom);
            i_is_imm   = 1'($urandom);
            i_rs1_data = $urandom;
            i_rs2_data = $urandom;
            i_shamt    = 5'($urandom);
            i_rd       = 5'($urandom);
            i_ready    = 1'($urandom_range(0, 2) != 0);
            i_rs1_idx  = 5'($urandom_range(0, 3));
            i_rs2_idx  = 5'($urandom_range(0, 3));
            i_wb_valid = 1'($urandom);
            i_wb_rd    = 5'($urandom_range(0, 3));
            i_wb_data  = $urandom;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shift_issue.md
SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result data width.
REQ-002 The block SHALL have parameter SHAMT_W, default 5, giving the shift-amount width, equal to log2(XLEN).
REQ-003 The block SHALL have port i_clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst_n, input, 1 bit, the reset: asynchronous, active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit, upstream instruction valid.
REQ-006 The block SHALL have port o_ready, output, 1 bit, the block accepts an instruction this cycle.
REQ-007 The block SHALL have port i_funct3, input, 3 bits, RISC-V funct3.
REQ-008 The block SHALL have port i_funct7b5, input, 1 bit, instruction bit 30.
REQ-009 The block SHALL have port i_is_imm, input, 1 bit, immediate form (SLLI/SRLI/SRAI).
REQ-010 The block SHALL have ports i_rs1_data and i_rs2_data, input, XLEN bits each, register operands.
REQ-011 The block SHALL have port i_shamt, input, SHAMT_W bits, immediate shift amount.
REQ-012 The block SHALL have port i_rd, input, 5 bits, destination register tag.
REQ-013 The block SHALL have ports i_wb_valid (1 bit), i_wb_rd (5 bits) and i_wb_data (XLEN bits), all inputs, the writeback forwarding source.
REQ-014 The block SHALL have ports o_valid (output, 1 bit) and i_ready (input, 1 bit), the downstream handshake.
REQ-015 The block SHALL have ports o_mode and o_direction, output, 1 bit each; o_mode 0 = logical, 1 = arithmetic; o_direction 0 = left, 1 = right.
REQ-016 The block SHALL have ports o_a and o_b, output, XLEN bits each, the shifter operands.
REQ-017 The block SHALL have ports o_rd (output, 5 bits) and o_illegal (output, 1 bit), the tag and the illegal-encoding flag.

Function
REQ-018 A transfer SHALL occur on an input when i_valid and o_ready are both 1, and on an output when o_valid and i_ready are both 1.
REQ-019 Buffering SHALL be a two-entry skid buffer with FSM states EMPTY, ONE and FULL.
- o_valid = (state != EMPTY); o_ready = (state != FULL).
REQ-020 FSM transitions SHALL be:
- EMPTY + push -> ONE.
- ONE + push, no pop -> FULL.
- ONE + pop, no push -> EMPTY.
- ONE + push + pop -> ONE.
- FULL + pop -> ONE, with the skid entry promoted to the output register.
- All other cases hold state.
REQ-021 Latency SHALL be 1 cycle from the input transfer to o_valid; sustained throughput SHALL be 1 per cycle while i_ready=1.
REQ-022 Output fields SHALL be registered and SHALL hold stable while o_valid=1 and i_ready=0.
REQ-023 Decode SHALL be:
- funct3=001 with funct7b5=0 -> mode 0, direction 0.
- funct3=101 with funct7b5=0 -> mode 0, direction 1.
- funct3=101 with funct7b5=1 -> mode 1, direction 1.
REQ-024 Any other funct3/funct7b5 combination SHALL set o_illegal=1, o_mode=0 and o_direction=0, and SHALL still flow through the handshake.
REQ-025 Operand forming SHALL be: o_a = rs1 operand; o_b = zero-extended i_shamt when i_is_imm=1, else zero-extended rs2[SHAMT_W-1:0]. Upper bits of o_b SHALL always be 0.
REQ-026 o_rd SHALL be the captured i_rd.

Reset
REQ-027 While i_rst_n=0 the block SHALL set: state EMPTY, o_valid=0, o_ready=0, and o_mode, o_direction, o_a, o_b, o_rd and o_illegal all 0.
REQ-028 o_ready SHALL rise in the first cycle after i_rst_n deasserts.
REQ-029 Reset asserted mid-operation SHALL discard all buffered entries immediately.

Configuration
REQ-030 Macro SHIFT_ISSUE_FWD_EN SHALL control forwarding.
- Defined: at capture, if i_wb_valid=1, i_wb_rd!=0 and i_wb_rd equals the instruction's rs index, rs1/rs2 data SHALL be replaced by i_wb_data. The rs1/rs2 indices come from upstream, tied off by default.
- Undefined: the i_wb_* ports SHALL exist but be ignored, with identical handshake timing.

Structure
REQ-031 A shared package SHALL hold the funct3 constants (SLL=3'b001, SR=3'b101), the FSM state enum, and the XLEN/SHAMT_W defaults.
REQ-032 One sub-module, shift_decode, SHALL hold the combinational decode (REQ-023/024); the FSM and buffer registers SHALL live in shift_issue.

Verification
REQ-033 The bench SHALL cover at least these directed scenarios:
- SRAI, rs1=0x8000_0000, shamt=4, i_ready=1 -> next cycle o_valid=1, mode=1, dir=1, o_a=0x8000_0000, o_b=4.
- SLL register form, rs2=0xFFFF_FF23 -> o_b=0x0000_0003, mode=0, dir=0.
- funct3=001 with funct7b5=1 -> o_illegal=1, handshake completes.
- i_ready=0 with 3 back-to-back pushes -> o_ready=0 after the 2nd push; the 3rd is held; after i_ready=1 all 3 emerge in order, none lost or duplicated.
- i_rst_n pulsed low while FULL -> o_valid=0 at once; no stale entry after release.
- With FWD_EN defined, i_wb_rd=5 matching rs1, i_wb_data=0x1234 -> o_a=0x1234; i_wb_rd=0 -> no forwarding.
